regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
Parametrised CPU register file: two combinational read ports, one write port, optional write-to-read bypass and a per-register busy scoreboard for pipelined hazard detection. Also provides a multi-cycle sequential clear engine driven by a command input. Sits in the decode stage of the pipelined CPU. It is the drop-in successor of the single-cycle register file.

Parameters:
ADDR_W, 5, register address width; depth DEPTH = 2**ADDR_W
DATA_W, 32, register data width
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = read returns stored value only

Ports:
Clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
Write_Reg  input  1  write enable
W_Addr  input  ADDR_W  write address
W_Data  input  DATA_W  write data
R_Addr_A  input  ADDR_W  read port A address
R_Addr_B  input  ADDR_W  read port B address
R_Data_A  output  DATA_W  read port A data (combinational)
R_Data_B  output  DATA_W  read port B data (combinational)
Issue_En  input  1  mark Issue_Addr busy (instruction issued, result pending)
Issue_Addr  input  ADDR_W  destination register of the issued instruction
Busy_A  output  1  register at R_Addr_A has a pending result
Busy_B  output  1  register at R_Addr_B has a pending result
Clr_Req  input  1  one-cycle pulse; start sequential clear of all registers
Clr_Busy  output  1  clear engine active

Behaviour:
- Reset (reset=0, asynchronous): all DEPTH registers = 0, all busy bits = 0, FSM = IDLE, clear counter = 1, Clr_Busy = 0. Outputs follow from this state: R_Data_* = 0, Busy_* = 0.
- Register 0 is hardwired to zero:
  - Reads of address 0 return 0.
  - Writes and issues to address 0 are ignored.
  - Busy bit 0 is always 0.
- Read (combinational, zero latency):
  - Default value is REG[R_Addr].
  - If BYPASS=1, FSM=IDLE, Write_Reg=1, W_Addr==R_Addr and W_Addr!=0, the port returns W_Data.
- Write: at the rising edge, REG[W_Addr] <= W_Data when Write_Reg=1, W_Addr!=0 and FSM=IDLE.
- Scoreboard, evaluated at the rising edge in IDLE:
  - A qualifying write clears busy[W_Addr].
  - Issue_En=1 with Issue_Addr!=0 sets busy[Issue_Addr].
  - If both act on the same address in the same cycle, set wins: a new producer was issued, so the bit ends at 1.
- Busy_A / Busy_B:
  - Equal to busy[R_Addr].
  - Exception: when BYPASS=1 and a qualifying write to the same address is present this cycle, the output is 0, because the data is available through the bypass.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on Clr_Req=1.
  - In CLEAR, each cycle sets REG[cnt] <= 0 and busy[cnt] <= 0, then cnt <= cnt+1.
  - When cnt == DEPTH-1, that entry is cleared, cnt <= 1 and the FSM returns to IDLE.
  - The clear takes exactly DEPTH-1 cycles.
  - Clr_Busy = 1 iff FSM = CLEAR, i.e. from the cycle after the request edge through the last clear cycle.
- During CLEAR:
  - Write_Reg and Issue_En are ignored (dropped, not queued).
  - Clr_Req is ignored.
  - Bypass is disabled.
  - Reads return current stored contents, which are partially cleared.
- Clr_Req and Write_Reg asserted in the same IDLE cycle: the write commits at that edge, then the clear begins and later zeros that register.
- Reset asserted mid-clear aborts immediately to the reset state.
- No arithmetic beyond the counter. The counter is ADDR_W bits wide and never wraps, because it is reloaded to 1 at DEPTH-1.

Test Plan:
1. Reset, then write 0xDEADBEEF to r5 and read r5 next cycle on A -> R_Data_A = 0xDEADBEEF. Write 0x1234 to r0 -> R_Data_B (addr 0) = 0.
2. BYPASS=1: Write_Reg=1, W_Addr=7, W_Data=0xA5A5A5A5, R_Addr_A=7 in the same cycle -> R_Data_A = 0xA5A5A5A5 before the edge. With BYPASS=0 -> R_Data_A = old value (0).
3. Issue r9 -> Busy_A(r9) = 1 next cycle. Write r9 -> Busy_A = 0 during the write cycle (BYPASS=1) and stays 0 after. Issue r9 and write r9 in the same cycle -> busy remains 1.
4. Fill r1..r31 with nonzero values and set busy on r3, then pulse Clr_Req:
   - Clr_Busy = 1 for exactly 31 cycles.
   - A write to r2 during CLEAR is dropped.
   - Afterwards all reads = 0 and Busy = 0.
5. Assert reset low mid-clear (cycle 10) -> all registers 0 and Clr_Busy = 0 immediately, without waiting for a clock edge. Release reset, write r4=0x55 -> reads 0x55.
6. ADDR_W=3, DATA_W=16: write r7=0xFFFF, then clear -> Clr_Busy = 1 for 7 cycles and r7 reads 0 afterwards.

Source files
------------

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_sb
//  Purpose  : Decode-stage CPU register file. Two combinational read ports,
//             one write port, optional same-cycle write-to-read bypass, a
//             per-register busy scoreboard for hazard detection and a
//             sequential clear engine that zeros r1..r(DEPTH-1), one entry
//             per cycle.
//  Ports    : Clk, reset (async, active-low)
//             Write_Reg/W_Addr/W_Data        - write port
//             R_Addr_A/B -> R_Data_A/B       - combinational read ports
//             Issue_En/Issue_Addr            - mark destination busy
//             Busy_A/B                       - pending-result flags for reads
//             Clr_Req -> Clr_Busy            - clear engine start / active
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_sb #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int BYPASS = 1
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              Write_Reg,
    input  logic [ADDR_W-1:0] W_Addr,
    input  logic [DATA_W-1:0] W_Data,
    input  logic [ADDR_W-1:0] R_Addr_A,
    input  logic [ADDR_W-1:0] R_Addr_B,
    output logic [DATA_W-1:0] R_Data_A,
    output logic [DATA_W-1:0] R_Data_B,
    input  logic              Issue_En,
    input  logic [ADDR_W-1:0] Issue_Addr,
    output logic              Busy_A,
    output logic              Busy_B,
    input  logic              Clr_Req,
    output logic              Clr_Busy
);

    localparam int              DEPTH     = 2**ADDR_W;
    localparam logic [0:0]      S_IDLE    = 1'b0;
    localparam logic [0:0]      S_CLEAR   = 1'b1;
    localparam logic [ADDR_W-1:0] LAST_IDX  = '1;
    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    logic idle, clearing, wr_ok, iss_ok, byp_a, byp_b;

    assign idle     = (state_q == S_IDLE);
    assign clearing = (state_q == S_CLEAR);

    // Writes and issues only take effect in IDLE and never to r0.
    assign wr_ok  = Write_Reg && (W_Addr != '0) && idle;
    assign iss_ok = Issue_En && (Issue_Addr != '0) && idle;

    // Forward write data when the read targets the register being written.
    assign byp_a = (BYPASS != 0) && wr_ok && (W_Addr == R_Addr_A);
    assign byp_b = (BYPASS != 0) && wr_ok && (W_Addr == R_Addr_B);

    assign R_Data_A = byp_a ? W_Data :
                      (R_Addr_A == '0) ? '0 : regs_q[R_Addr_A];
    assign R_Data_B = byp_b ? W_Data :
                      (R_Addr_B == '0) ? '0 : regs_q[R_Addr_B];

    // A forwarded result is not a hazard, so busy is masked under bypass.
    assign Busy_A = byp_a ? 1'b0 : busy_q[R_Addr_A];
    assign Busy_B = byp_b ? 1'b0 : busy_q[R_Addr_B];

    assign Clr_Busy = clearing;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        case (state_q)
            S_IDLE: begin
                if (wr_ok) begin
                    busy_d[W_Addr] = 1'b0;
                end
                // Issue applied after write: a new producer wins the race.
                if (iss_ok) begin
                    busy_d[Issue_Addr] = 1'b1;
                end
                if (Clr_Req) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                busy_d[cnt_q] = 1'b0;
                if (cnt_q == LAST_IDX) begin
                    state_d = S_IDLE;
                    cnt_d   = FIRST_IDX;
                end else begin
                    cnt_d = cnt_q + FIRST_IDX;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= FIRST_IDX;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // wr_ok and clearing are mutually exclusive (wr_ok requires IDLE).
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_ok) begin
            regs_q[W_Addr] <= W_Data;
        end else if (clearing) begin
            regs_q[cnt_q] <= '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_sb
//  Purpose  : Self-checking bench for regfile_sb. Three instances: default
//             (bypass on), bypass off sharing the same stimulus, and a small
//             ADDR_W=3/DATA_W=16 instance for the short clear sequence.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        reset;
    logic        wr, iss, clr;
    logic [4:0]  wa, ra, rb, ia;
    logic [31:0] wd;
    logic [31:0] rda, rdb, n_rda, n_rdb;
    logic        ba, bb, cb, n_ba, n_bb, n_cb;

    logic        s_wr, s_iss, s_clr;
    logic [2:0]  s_wa, s_ra, s_rb, s_ia;
    logic [15:0] s_wd, s_rda, s_rdb;
    logic        s_ba, s_bb, s_cb;

    regfile_sb #(.ADDR_W(5), .DATA_W(32), .BYPASS(1)) u_dut (
        .Clk(Clk), .reset(reset), .Write_Reg(wr), .W_Addr(wa), .W_Data(wd),
        .R_Addr_A(ra), .R_Addr_B(rb), .R_Data_A(rda), .R_Data_B(rdb),
        .Issue_En(iss), .Issue_Addr(ia), .Busy_A(ba), .Busy_B(bb),
        .Clr_Req(clr), .Clr_Busy(cb)
    );

    regfile_sb #(.ADDR_W(5), .DATA_W(32), .BYPASS(0)) u_nb (
        .Clk(Clk), .reset(reset), .Write_Reg(wr), .W_Addr(wa), .W_Data(wd),
        .R_Addr_A(ra), .R_Addr_B(rb), .R_Data_A(n_rda), .R_Data_B(n_rdb),
        .Issue_En(iss), .Issue_Addr(ia), .Busy_A(n_ba), .Busy_B(n_bb),
        .Clr_Req(clr), .Clr_Busy(n_cb)
    );

    regfile_sb #(.ADDR_W(3), .DATA_W(16), .BYPASS(1)) u_sm (
        .Clk(Clk), .reset(reset), .Write_Reg(s_wr), .W_Addr(s_wa), .W_Data(s_wd),
        .R_Addr_A(s_ra), .R_Addr_B(s_rb), .R_Data_A(s_rda), .R_Data_B(s_rdb),
        .Issue_En(s_iss), .Issue_Addr(s_ia), .Busy_A(s_ba), .Busy_B(s_bb),
        .Clr_Req(s_clr), .Clr_Busy(s_cb)
    );

    typedef struct {
        logic        w;
        logic [4:0]  a;
        logic [31:0] d;
        logic [4:0]  x;
        logic [4:0]  y;
        logic        i;
        logic [4:0]  ix;
        logic [31:0] rda;
        logic [31:0] rdb;
        logic        ba;
        logic        bb;
        logic [31:0] nrda;
        logic        nba;
    } vec_t;

    typedef struct {
        logic [31:0] rda;
        logic [31:0] rdb;
        logic        ba;
        logic        bb;
        logic [31:0] nrda;
        logic        nba;
    } exp_t;

    localparam int NV = 13;
    vec_t vec [NV];
    exp_t sb [$];
    exp_t e;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic drv(input logic w, input logic [4:0] a, input logic [31:0] d,
                       input logic [4:0] x, input logic [4:0] y,
                       input logic i, input logic [4:0] ix, input logic c);
        wr = w; wa = a; wd = d; ra = x; rb = y; iss = i; ia = ix; clr = c;
    endtask

    task automatic idle();
        drv(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    endtask

    initial begin
        int cyc;

        //           w     a      d              x      y      i     ix     rda            rdb            ba    bb    nrda           nba
        vec[0]  = '{1'b0, 5'd0, 32'h0,         5'd0, 5'd0, 1'b0, 5'd0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0,         1'b0};
        vec[1]  = '{1'b1, 5'd5, 32'hDEADBEEF,  5'd5, 5'd0, 1'b0, 5'd0, 32'hDEADBEEF,  32'h0,         1'b0, 1'b0, 32'h0,         1'b0};
        vec[2]  = '{1'b1, 5'd0, 32'h1234,      5'd5, 5'd0, 1'b0, 5'd0, 32'hDEADBEEF,  32'h0,         1'b0, 1'b0, 32'hDEADBEEF,  1'b0};
        vec[3]  = '{1'b0, 5'd0, 32'h0,         5'd0, 5'd5, 1'b0, 5'd0, 32'h0,         32'hDEADBEEF,  1'b0, 1'b0, 32'h0,         1'b0};
        vec[4]  = '{1'b1, 5'd7, 32'hA5A5A5A5,  5'd7, 5'd5, 1'b0, 5'd0, 32'hA5A5A5A5,  32'hDEADBEEF,  1'b0, 1'b0, 32'h0,         1'b0};
        vec[5]  = '{1'b0, 5'd0, 32'h0,         5'd9, 5'd7, 1'b1, 5'd9, 32'h0,         32'hA5A5A5A5,  1'b0, 1'b0, 32'h0,         1'b0};
        vec[6]  = '{1'b0, 5'd0, 32'h0,         5'd9, 5'd9, 1'b0, 5'd0, 32'h0,         32'h0,         1'b1, 1'b1, 32'h0,         1'b1};
        vec[7]  = '{1'b1, 5'd9, 32'h99,        5'd9, 5'd9, 1'b0, 5'd0, 32'h99,        32'h99,        1'b0, 1'b0, 32'h0,         1'b1};
        vec[8]  = '{1'b0, 5'd0, 32'h0,         5'd9, 5'd0, 1'b0, 5'd0, 32'h99,        32'h0,         1'b0, 1'b0, 32'h99,        1'b0};
        vec[9]  = '{1'b1, 5'd9, 32'h1111,      5'd9, 5'd0, 1'b1, 5'd9, 32'h1111,      32'h0,         1'b0, 1'b0, 32'h99,        1'b0};
        vec[10] = '{1'b0, 5'd0, 32'h0,         5'd9, 5'd0, 1'b0, 5'd0, 32'h1111,      32'h0,         1'b1, 1'b0, 32'h1111,      1'b1};
        vec[11] = '{1'b0, 5'd0, 32'h0,         5'd0, 5'd0, 1'b1, 5'd0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0,         1'b0};
        vec[12] = '{1'b0, 5'd0, 32'h0,         5'd0, 5'd0, 1'b0, 5'd0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0,         1'b0};

        reset = 1'b0;
        idle();
        s_wr = 1'b0; s_wa = 3'd0; s_wd = 16'd0; s_ra = 3'd0; s_rb = 3'd0;
        s_iss = 1'b0; s_ia = 3'd0; s_clr = 1'b0;
        repeat (2) @(negedge Clk);
        check("reset clr_busy", 32'(cb), 32'd0);
        reset = 1'b1;

        // Table-driven read/write/bypass/scoreboard vectors.
        for (int k = 0; k < NV; k++) begin
            @(negedge Clk);
            drv(vec[k].w, vec[k].a, vec[k].d, vec[k].x, vec[k].y, vec[k].i, vec[k].ix, 1'b0);
            sb.push_back('{vec[k].rda, vec[k].rdb, vec[k].ba, vec[k].bb, vec[k].nrda, vec[k].nba});
            #4;
            e = sb.pop_front();
            check($sformatf("v%0d rda", k),   rda,        e.rda);
            check($sformatf("v%0d rdb", k),   rdb,        e.rdb);
            check($sformatf("v%0d busyA", k), 32'(ba),    32'(e.ba));
            check($sformatf("v%0d busyB", k), 32'(bb),    32'(e.bb));
            check($sformatf("v%0d nb rda", k), n_rda,     e.nrda);
            check($sformatf("v%0d nb busyA", k), 32'(n_ba), 32'(e.nba));
        end

        // Fill r1..r31, mark r3 busy, then clear with a coincident write to r2.
        for (int r = 1; r < 32; r++) begin
            @(negedge Clk);
            drv(1'b1, 5'(r), 32'(r) * 32'h01010101, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        end
        @(negedge Clk);
        drv(1'b0, 5'd0, 32'd0, 5'd31, 5'd0, 1'b1, 5'd3, 1'b0);
        #1 check("fill r31", rda, 32'h1F1F1F1F);
        @(negedge Clk);
        drv(1'b1, 5'd2, 32'hBEEF, 5'd3, 5'd0, 1'b0, 5'd0, 1'b1);
        #1;
        check("pre-clear busy r3", 32'(ba), 32'd1);
        check("clr_busy at request", 32'(cb), 32'd0);

        cyc = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge Clk);
            case (k)
                0:       drv(1'b1, 5'd2, 32'h7777, 5'd2, 5'd3, 1'b0, 5'd0, 1'b0);
                4:       drv(1'b1, 5'd2, 32'h2222, 5'd2, 5'd0, 1'b1, 5'd1, 1'b0);
                5:       drv(1'b0, 5'd0, 32'd0,    5'd2, 5'd1, 1'b0, 5'd0, 1'b1);
                default: idle();
            endcase
            #1;
            if (!cb) break;
            cyc++;
            check($sformatf("nb clr_busy c%0d", k), 32'(n_cb), 32'd1);
            if (k == 0) begin
                check("clear r2 no bypass", rda, 32'hBEEF);
                check("clear busy r3 pending", 32'(bb), 32'd1);
            end
            if (k == 4) check("clear write dropped now", rda, 32'd0);
            if (k == 5) begin
                check("clear write dropped after", rda, 32'd0);
                check("clear issue dropped", 32'(bb), 32'd0);
            end
        end
        check("clear cycles", 32'(cyc), 32'd31);

        for (int a = 0; a < 32; a++) begin
            @(negedge Clk);
            drv(1'b0, 5'd0, 32'd0, 5'(a), 5'(a), 1'b0, 5'd0, 1'b0);
            #1;
            check($sformatf("post-clear r%0d", a), rda, 32'd0);
            check($sformatf("post-clear busy%0d", a), 32'(ba), 32'd0);
            check($sformatf("nb post-clear r%0d", a), n_rdb, 32'd0);
            check($sformatf("nb post-clear busy%0d", a), 32'(n_bb), 32'd0);
        end

        // Reset asserted between edges during a clear.
        @(negedge Clk);
        drv(1'b1, 5'd31, 32'hCAFE, 5'd0, 5'd0, 1'b1, 5'd30, 1'b0);
        @(negedge Clk);
        drv(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1);
        @(negedge Clk);
        idle();
        repeat (9) @(negedge Clk);
        drv(1'b0, 5'd0, 32'd0, 5'd31, 5'd30, 1'b0, 5'd0, 1'b0);
        #1;
        check("mid-clear r31", rda, 32'hCAFE);
        check("mid-clear busy r30", 32'(bb), 32'd1);
        check("mid-clear clr_busy", 32'(cb), 32'd1);
        #1 reset = 1'b0;
        #1;
        check("async reset clr_busy", 32'(cb), 32'd0);
        check("async reset r31", rda, 32'd0);
        check("async reset busy r30", 32'(bb), 32'd0);
        @(negedge Clk);
        reset = 1'b1;
        @(negedge Clk);
        drv(1'b1, 5'd4, 32'h55, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        @(negedge Clk);
        drv(1'b0, 5'd0, 32'd0, 5'd4, 5'd0, 1'b0, 5'd0, 1'b0);
        #1 check("post-reset r4", rda, 32'h55);

        // Small instance: 8 entries, 7-cycle clear.
        @(negedge Clk);
        s_wr = 1'b1; s_wa = 3'd7; s_wd = 16'hFFFF; s_ra = 3'd7;
        @(negedge Clk);
        s_wr = 1'b0;
        #1 check("small r7", 32'(s_rda), 32'h0000FFFF);
        @(negedge Clk);
        s_clr = 1'b1;
        cyc = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge Clk);
            s_clr = 1'b0;
            #1;
            if (!s_cb) break;
            cyc++;
        end
        check("small clear cycles", 32'(cyc), 32'd7);
        check("small r7 cleared", 32'(s_rda), 32'd0);
        check("small busyA", 32'(s_ba), 32'd0);
        check("small r0 B", 32'(s_rdb), 32'd0);
        check("small busyB", 32'(s_bb), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
